// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Feeds per-digit seven-segment decoders through a start/busy/done handshake.
// Optional feature macro: BIN2BCD_BLANK_EN enables the leading-zero blank mask on o_blank;
// when undefined o_blank is tied to zero.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_ovf,
   output logic [DIGITS-1:0]     o_blank
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef BIN2BCD_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
`else
   localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   shreg;
   logic [BCD_W-1:0]   scratch;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   scratch_nxt;
   logic               ovf;
   logic               ovf_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               start_ok;
   logic               last_shift;
   logic [DIGITS-1:0]  blank_nxt;

   // Start is only honoured when not mid-conversion; last_shift marks the edge entering DONE
   always_comb begin
      start_ok   = i_start && ((state == IDLE) || (state == DONE));
      last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = i_start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-digit add-3 (no inter-digit carry), then shift one binary bit into the scratch
   always_comb begin
      adj = scratch;
      for (int n = 0; n < int'(DIGITS); n++) begin
         if (scratch[4*n +: 4] >= 4'd5) adj[4*n +: 4] = scratch[4*n +: 4] + 4'd3;
      end
      scratch_nxt = {adj[BCD_W-2:0], shreg[WIDTH-1]};
      ovf_nxt     = ovf | adj[BCD_W-1];
   end

`ifdef BIN2BCD_BLANK_EN
   // Leading-zero mask over the final result; units digit is never blanked
   always_comb begin
      logic all_zero;
      all_zero  = 1'b1;
      blank_nxt = '0;
      for (int n = int'(DIGITS) - 1; n >= 1; n--) begin
         all_zero     = all_zero && (scratch_nxt[4*n +: 4] == 4'd0);
         blank_nxt[n] = all_zero;
      end
      if (ovf_nxt) blank_nxt = '0;
   end
`else
   // Blanking disabled: mask is constant zero
   always_comb begin
      blank_nxt = '0;
   end
`endif

   // Conversion datapath: capture on accepted start, shift while in SHIFT
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         scratch <= '0;
         ovf     <= 1'b0;
         cnt     <= '0;
      end else if (start_ok) begin
         shreg   <= i_bin;
         scratch <= '0;
         ovf     <= 1'b0;
         cnt     <= CNT_W'(WIDTH);
      end else if (state == SHIFT) begin
         shreg   <= shreg << 1;
         scratch <= scratch_nxt;
         ovf     <= ovf_nxt;
         cnt     <= cnt - CNT_W'(1);
      end
   end

   // Registered outputs; results load only on the edge entering DONE and hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_bcd   <= '0;
         o_ovf   <= 1'b0;
         o_blank <= BLANK_RST;
      end else begin
         o_busy <= (state_nxt == SHIFT);
         o_done <= (state_nxt == DONE);
         if (last_shift) begin
            o_ovf   <= ovf_nxt;
            o_bcd   <= ovf_nxt ? {DIGITS{4'h9}} : scratch_nxt;
            o_blank <= blank_nxt;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq, running a 5-digit and a 4-digit
// instance in lockstep. Expected results come from a hand-computed lookup table.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [15:0] i_bin;

   logic        d5_busy, d5_done, d5_ovf;
   logic [19:0] d5_bcd;
   logic [4:0]  d5_blank;
   logic        d4_busy, d4_done, d4_ovf;
   logic [15:0] d4_bcd;
   logic [3:0]  d4_blank;

   typedef struct packed {
      logic [19:0] bcd5;
      logic        ovf5;
      logic [4:0]  blk5;
      logic [15:0] bcd4;
      logic        ovf4;
      logic [3:0]  blk4;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [19:0] hold_ref = '0;
   int          n_cmp = 0;
   int          n_err = 0;

`ifdef BIN2BCD_BLANK_EN
   localparam logic [4:0] RST_BLK5 = 5'b11110;
   localparam logic [3:0] RST_BLK4 = 4'b1110;
`else
   localparam logic [4:0] RST_BLK5 = 5'b00000;
   localparam logic [3:0] RST_BLK4 = 4'b0000;
`endif

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_d5 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_bin(i_bin),
      .o_busy(d5_busy), .o_done(d5_done), .o_bcd(d5_bcd), .o_ovf(d5_ovf), .o_blank(d5_blank)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_d4 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_bin(i_bin),
      .o_busy(d4_busy), .o_done(d4_done), .o_bcd(d4_bcd), .o_ovf(d4_ovf), .o_blank(d4_blank)
   );

   always #5 clk = ~clk;

   // Hand-computed results: {bcd5, ovf5, blank5, bcd4, ovf4, blank4} with blanking enabled
   function automatic exp_t lookup(input logic [15:0] v);
      exp_t e;
      case (v)
         16'hFFFF: e = '{20'h65535, 1'b0, 5'b00000, 16'h9999, 1'b1, 4'b0000};
         16'd0:    e = '{20'h00000, 1'b0, 5'b11110, 16'h0000, 1'b0, 4'b1110};
         16'd42:   e = '{20'h00042, 1'b0, 5'b11100, 16'h0042, 1'b0, 4'b1100};
         16'd10000:e = '{20'h10000, 1'b0, 5'b00000, 16'h9999, 1'b1, 4'b0000};
         16'd9999: e = '{20'h09999, 1'b0, 5'b10000, 16'h9999, 1'b0, 4'b0000};
         16'd1000: e = '{20'h01000, 1'b0, 5'b10000, 16'h1000, 1'b0, 4'b0000};
         16'd7:    e = '{20'h00007, 1'b0, 5'b11110, 16'h0007, 1'b0, 4'b1110};
         16'd123:  e = '{20'h00123, 1'b0, 5'b11000, 16'h0123, 1'b0, 4'b1000};
         16'd12345:e = '{20'h12345, 1'b0, 5'b00000, 16'h9999, 1'b1, 4'b0000};
         default:  e = '1;
      endcase
`ifndef BIN2BCD_BLANK_EN
      e.blk5 = '0;
      e.blk4 = '0;
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected entry per o_done and checks both instances
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         hold_ref = '0;
      end else begin
         if (d5_busy === 1'b1) chk("hold_bcd_during_busy", 32'(d5_bcd), 32'(hold_ref));
         if (d5_done === 1'b1 || d4_done === 1'b1) begin
            chk("done_sync", 32'(d4_done), 32'(d5_done));
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got o_done=1 expected no pending conversion (t=%0t)", $time);
            end else begin
               mon_e = q.pop_front();
               chk("bcd5",   32'(d5_bcd),   32'(mon_e.bcd5));
               chk("ovf5",   32'(d5_ovf),   32'(mon_e.ovf5));
               chk("blank5", 32'(d5_blank), 32'(mon_e.blk5));
               chk("bcd4",   32'(d4_bcd),   32'(mon_e.bcd4));
               chk("ovf4",   32'(d4_ovf),   32'(mon_e.ovf4));
               chk("blank4", 32'(d4_blank), 32'(mon_e.blk4));
               hold_ref = mon_e.bcd5;
            end
         end
      end
   end

   // Wait for o_done from just after an accepting edge; checks latency and busy length
   task automatic wait_done(input int glitch_at);
      int cyc;
      int busy_n;
      cyc    = 0;
      busy_n = 0;
      while (d5_done !== 1'b1 && cyc < 40) begin
         if (d5_busy === 1'b1) busy_n++;
         if (cyc == glitch_at) begin
            i_start = 1'b1;
            i_bin   = 16'd123;
         end else if (glitch_at >= 0) begin
            i_start = 1'b0;
            i_bin   = 16'(cyc * 16'd977);
         end
         @(posedge clk); #1;
         cyc++;
      end
      // counted including the cycle in which start was presented
      chk("done_latency", 32'(cyc + 1), 32'd17);
      chk("busy_cycles", 32'(busy_n), 32'd16);
      chk("busy_low_in_done", 32'(d5_busy), 32'd0);
   endtask

   task automatic run_one(input logic [15:0] v, input int glitch_at);
      i_bin   = v;
      i_start = 1'b1;
      @(posedge clk);
      q.push_back(lookup(v));
      #1;
      i_start = 1'b0;
      i_bin   = 16'h5A5A;
      wait_done(glitch_at);
      i_start = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse_width", 32'(d5_done), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"},   32'(d5_busy),  32'd0);
      chk({tag, "_done"},   32'(d5_done),  32'd0);
      chk({tag, "_ovf"},    32'(d5_ovf),   32'd0);
      chk({tag, "_bcd5"},   32'(d5_bcd),   32'd0);
      chk({tag, "_blank5"}, 32'(d5_blank), 32'(RST_BLK5));
      chk({tag, "_bcd4"},   32'(d4_bcd),   32'd0);
      chk({tag, "_blank4"}, 32'(d4_blank), 32'(RST_BLK4));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      rst     = 1'b1;
      i_start = 1'b0;
      i_bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed single conversions, including overflow boundaries for 4 digits
      run_one(16'hFFFF, -1);
      run_one(16'd0, -1);
      run_one(16'd42, -1);
      run_one(16'd10000, -1);
      run_one(16'd9999, -1);

      // Start pulse and i_bin churn during busy must be ignored
      run_one(16'd1000, 4);
      repeat (20) @(posedge clk);
      #1;

      // i_start held high: back-to-back conversions of 7
      i_bin   = 16'd7;
      i_start = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(posedge clk);
         q.push_back(lookup(16'd7));
         #1;
         wait_done(-1);
         if (t == 2) i_start = 1'b0;
      end
      @(posedge clk); #1;
      chk("held_done_pulse_width", 32'(d5_done), 32'd0);
      chk("held_idle_after", 32'(d5_busy), 32'd0);

      // Reset mid-SHIFT discards the conversion
      i_bin   = 16'd12345;
      i_start = 1'b1;
      @(posedge clk);
      q.push_back(lookup(16'd12345));
      #1;
      i_start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("busy_before_rst", 32'(d5_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_state("midshift_rst");
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (d5_done === 1'b1) seen++;
      end
      chk("no_done_after_rst", 32'(seen), 32'd0);
      run_one(16'd123, -1);

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
